// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default word-address and data widths.
//   owner_t, OWN_NONE / OWN_I / OWN_D : encoding of which side owns an access.
//   STALL_MAX : saturation value of the stall counter.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 14;
   localparam int unsigned DATA_W_DEFAULT = 32;

   typedef logic [1:0] owner_t;

   localparam owner_t OWN_NONE = 2'd0;
   localparam owner_t OWN_I    = 2'd1;
   localparam owner_t OWN_D    = 2'd2;

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the shared memory.
//   Fetch side   : i_req, i_addr -> i_gnt, i_valid, i_rdata
//   Data side    : d_req, d_we, d_addr, d_wdata -> d_gnt, d_valid, d_rdata
//   Memory side  : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   Status       : pc_stall, stall_cnt
// Modport slave is the arbiter's view; master is the CPU/memory environment's view.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT
);

   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_gnt;
   logic              i_valid;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              pc_stall;
   logic [15:0]       stall_cnt;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, pc_stall, stall_cnt
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, pc_stall, stall_cnt
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between the fetch (i) and data (d) requesters.
//   clk, rst_n   : clock and synchronous active-low reset
//   i_req, d_req : requests, held until granted
//   i_gnt, d_gnt : one-cycle grants, never both high, forced low in reset
// The last-owner register moves only on a grant; it resets to the fetch side so
// that data wins the first contested cycle.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic d_req,
   output logic i_gnt,
   output logic d_gnt
);

   owner_t last_q, last_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= OWN_I;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (rst_n) begin
         if (i_req && d_req) begin
            // Contested: the side not served most recently wins.
            if (last_q == OWN_D) i_gnt = 1'b1;
            else                 d_gnt = 1'b1;
         end else begin
            i_gnt = i_req;
            d_gnt = d_req;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (d_gnt)      last_d = OWN_D;
      else if (i_gnt) last_d = OWN_I;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (fetch, data, memory and stall signals)
// Grant and memory issue are combinational in cycle T; the response (valid + rdata)
// appears in T+1, and a new grant may issue in that same cycle.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.slave  bus
);

   logic        i_gnt, d_gnt;
   logic        pc_stall;
   owner_t      owner_q, owner_d;
   owner_t      owner_vis;
   logic        we_q;
   logic [15:0] stall_cnt_q;

   // Byte-offset bits and bits above the memory range do not address memory.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                               bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (bus.i_req),
      .d_req (bus.d_req),
      .i_gnt (i_gnt),
      .d_gnt (d_gnt)
   );

   assign pc_stall = bus.i_req & ~i_gnt;

   always_comb begin
      owner_d = OWN_NONE;
      if (d_gnt)      owner_d = OWN_D;
      else if (i_gnt) owner_d = OWN_I;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q     <= OWN_NONE;
         we_q        <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         owner_q <= owner_d;
         we_q    <= d_gnt & bus.d_we;
         if (pc_stall && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   // A response pending when reset arrives is dropped immediately, not just next cycle.
   assign owner_vis = rst_n ? owner_q : OWN_NONE;

   always_comb begin
      bus.i_gnt     = i_gnt;
      bus.d_gnt     = d_gnt;
      bus.mem_en    = i_gnt | d_gnt;
      bus.mem_we    = d_gnt & bus.d_we;
      bus.mem_addr  = d_gnt ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.d_wdata;
      bus.pc_stall  = pc_stall;
      bus.stall_cnt = stall_cnt_q;

      bus.i_valid = (owner_vis == OWN_I);
      bus.d_valid = (owner_vis == OWN_D);
      bus.i_rdata = bus.i_valid ? bus.mem_rdata : '0;
      bus.d_rdata = (bus.d_valid && !we_q) ? bus.mem_rdata : '0;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 i_req  in  1  instruction fetch request; held high until granted.
REQ-007 i_addr  in  32  byte address (PC) of the fetch.
REQ-008 i_gnt  out  1  fetch accepted this cycle.
REQ-009 i_valid  out  1  i_rdata valid this cycle.
REQ-010 i_rdata  out  DATA_W  fetched instruction.
REQ-011 d_req  in  1  load/store request; held high until granted.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  32  byte address of the data access.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_gnt  out  1  data access accepted this cycle.
REQ-016 d_valid  out  1  load data valid, or store completed.
REQ-017 d_rdata  out  DATA_W  load data; 0 for stores.
REQ-018 pc_stall  out  1  hold PC: equals i_req AND NOT i_gnt.
REQ-019 mem_en, mem_we  out  1 each  memory enable and write enable.
REQ-020 mem_addr  out  ADDR_W  word address.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en.
REQ-023 stall_cnt  out  16  saturating count of cycles with pc_stall high.

Function
REQ-024 Issue SHALL be combinational in cycle T: at most one of i_gnt/d_gnt high; mem_en = i_gnt OR d_gnt.
REQ-025 On grant, mem_addr SHALL be the winner's addr[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 are ignored.
REQ-026 mem_we SHALL be d_gnt AND d_we; mem_wdata SHALL be d_wdata.
REQ-027 With exactly one requester active, that requester SHALL be granted.
REQ-028 With both active, the requester not granted most recently wins; after reset, data wins first.
REQ-029 last_owner SHALL update only on a grant.
REQ-030 Response SHALL arrive in T+1: owner_q/we_q are registered; i_valid or d_valid is high for exactly one cycle.
REQ-031 In the response cycle, i_rdata/d_rdata SHALL equal mem_rdata for a read; d_rdata SHALL be 0 for a store; the non-owner rdata SHALL hold 0.
REQ-032 A new grant SHALL be allowed in the response cycle, giving throughput of one access per cycle.
REQ-033 stall_cnt SHALL increment when pc_stall is high and saturate at 16'hFFFF.

Reset
REQ-034 While rst_n is low at a clock edge, the block SHALL clear owner_q and all valids to 0, set last_owner = instruction (so data wins first), and clear stall_cnt; gnt outputs are forced low and no memory enable is issued.
REQ-035 Reset asserted during an outstanding access SHALL discard the response; no valid is asserted in the following cycle.

Structure
REQ-036 A shared package SHALL hold owner encoding constants (OWN_NONE, OWN_I, OWN_D) and the default ADDR_W/DATA_W values.
REQ-037 A single sub-module rr_arb2 (2-way round-robin grant plus last-owner register) SHALL implement the arbitration; all other logic stays flat.

Verification
REQ-038 Fetch only: i_req=1, i_addr=0x18, mem returns 0x012A0000 -> i_gnt at T, mem_addr=6, i_valid with i_rdata=0x012A0000 at T+1, pc_stall=0.
REQ-039 Simultaneous requests after reset: i_req=d_req=1 (load at 0x40) -> d_gnt at T, i_gnt at T+1, pc_stall=1 for one cycle, stall_cnt=1.
REQ-040 Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=4, d_valid at T+1 with d_rdata=0.
REQ-041 Continuous dual requests for 6 cycles -> grants alternate D,I,D,I,D,I; valids follow one cycle later with the correct owner.
REQ-042 Reset mid-access: rst_n=0 in the cycle after a load grant -> d_valid=0, all grants 0, stall_cnt=0.
REQ-043 Saturation: force stall for 65540 cycles -> stall_cnt holds at 0xFFFF.
